// File: rtl/compare_sort_ctrl.sv
// compare_sort_ctrl: loads a byte burst, stable in-place bubble sort on one shared comparator, streams it out ascending
module compare_sort_ctrl #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] swap_cnt
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t state, state_nx;
  logic [7:0] mem [N];
  logic [IW-1:0] wr, rd, i, p;
  logic [CW-1:0] n;
  logic pass_swapped;
  logic [7:0] a, b;
  logic gt, accept, burst_end, end_pass, sort_done, rd_last;
  always_comb begin
    a = mem[i];
    b = mem[i + IW'(1)];
    gt = a > b;
    accept = in_valid && state == LOAD;
    burst_end = accept && (in_last || wr == IW'(N - 1));
    end_pass = CW'(i) == n - CW'(2) - CW'(p);
    // a pass with no swap, counting this cycle's, proves the array is sorted
    sort_done = end_pass && (!(pass_swapped || gt) || CW'(p) == n - CW'(2));
    rd_last = CW'(rd) == n - CW'(1);
    state_nx = state;
    case (state)
      LOAD:    state_nx = burst_end ? (wr == '0 ? DRAIN : SORT) : LOAD;
      SORT:    state_nx = sort_done ? DRAIN : SORT;
      default: state_nx = out_ready && rd_last ? LOAD : DRAIN;
    endcase
    in_ready = state == LOAD;
    out_valid = state == DRAIN;
    busy = state != LOAD;
    out_data = out_valid ? mem[rd] : 8'd0;
    out_last = out_valid && rd_last;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      wr <= '0;
      rd <= '0;
      i <= '0;
      p <= '0;
      n <= CW'(1);
      swap_cnt <= '0;
      pass_swapped <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: if (accept) begin
          mem[wr] <= in_data;
          wr <= burst_end ? '0 : wr + IW'(1);
          if (burst_end) begin
            n <= CW'(wr) + CW'(1);
            swap_cnt <= '0;
            i <= '0;
            p <= '0;
            rd <= '0;
            pass_swapped <= 1'b0;
          end
        end
        SORT: begin
          if (gt) begin
            mem[i] <= b;
            mem[i + IW'(1)] <= a;
            swap_cnt <= swap_cnt + 8'd1;
            pass_swapped <= 1'b1;
          end
          if (!end_pass) i <= i + IW'(1);
          else if (sort_done) rd <= '0;
          else begin
            p <= p + IW'(1);
            i <= '0;
            pass_swapped <= 1'b0;
          end
        end
        default: if (out_ready) begin
          rd <= rd_last ? '0 : rd + IW'(1);
          if (rd_last) wr <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_compare_sort_ctrl.sv
// tb_compare_sort_ctrl: randomized bursts checked against a sort/inversion-count reference model
module tb_compare_sort_ctrl;
  localparam int N = 8;
  typedef logic [7:0] bq_t [$];
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, out_last, busy;
  logic [7:0] out_data, swap_cnt;
  int checks = 0, failures = 0;
  compare_sort_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .swap_cnt(swap_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic load_bytes(input bq_t d, input bit use_last);
    for (int k = 0; k < d.size(); k++) begin
      do begin
        @(negedge clk);
        in_valid = $urandom_range(3) != 0;
      end while (!in_valid);
      in_data = d[k];
      in_last = use_last && k == d.size() - 1;
      check("in_ready_load", in_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic run_burst(input bq_t d, input bit use_last, input int stall);
    bq_t s;
    int n, inv, m, passes, cmp, k, idx, guard;
    n = d.size();
    s = d;
    s.sort();
    inv = 0;
    m = 0;
    for (int j = 0; j < n; j++) begin
      int c = 0;
      for (int q = 0; q < j; q++) if (d[q] > d[j]) c++;
      inv += c;
      if (c > m) m = c;
    end
    passes = n < 2 ? 0 : (m + 1 < n - 1 ? m + 1 : n - 1);
    cmp = 0;
    for (int q = 0; q < passes; q++) cmp += n - 1 - q;
    load_bytes(d, use_last);
    check("in_ready_after_burst", in_ready, 0);
    k = 0;
    while (!out_valid && k < 300) begin
      k++;
      @(negedge clk);
    end
    check("sort_latency", k, cmp);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 1000) begin
      guard++;
      check("out_valid", out_valid, 1);
      check("out_data", out_data, s[idx]);
      check("out_last", out_last, idx == n - 1);
      check("in_ready_drain", in_ready, 0);
      check("busy_drain", busy, 1);
      check("swap_cnt", swap_cnt, inv);
      out_ready = $urandom_range(99) >= stall;
      @(posedge clk);
      if (out_ready) idx++;
      @(negedge clk);
    end
    out_ready = 0;
    check("drain_count", idx, n);
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
    check("out_data_after", out_data, 0);
    check("busy_after", busy, 0);
    check("swap_cnt_hold", swap_cnt, inv);
  endtask
  initial begin
    bq_t q;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_swap_cnt", swap_cnt, 0);
    rst_n = 1;
    q = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_burst(q, 1, 0);
    q = '{8, 7, 6, 5, 4, 3, 2, 1};
    run_burst(q, 1, 0);
    q = '{255, 0, 7, 7, 128};
    run_burst(q, 1, 0);
    q = '{42};
    run_burst(q, 1, 30);
    q = '{3, 1, 2, 0, 0, 0, 0, 9};
    run_burst(q, 0, 50);
    q = '{8, 7, 6, 5, 4, 3, 2, 1};
    load_bytes(q, 1);
    repeat (5) @(negedge clk);
    check("busy_mid_sort", busy, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_swap_cnt", swap_cnt, 0);
    check("midrst_out_valid", out_valid, 0);
    q = '{5, 4};
    run_burst(q, 1, 20);
    for (int t = 0; t < 25; t++) begin
      int len = $urandom_range(1, N);
      bit wide = $urandom_range(1) != 0;
      q = {};
      for (int j = 0; j < len; j++) q.push_back(8'(wide ? $urandom_range(255) : $urandom_range(5)));
      run_burst(q, len < N ? 1'b1 : 1'($urandom_range(1)), $urandom_range(60));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
